// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared word type and port identifiers for the memory arbiter.
package mem_port_arbiter_pkg;
    typedef logic [31:0] rv32i_word;
    typedef enum logic {ARB_A = 1'b0, ARB_B = 1'b1} arb_port_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU-side ports A/B and the physical memory port seen by the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;
    logic      read_a;
    rv32i_word address_a;
    logic      resp_a;
    rv32i_word rdata_a;
    logic      read_b;
    logic      write;
    logic [3:0] wmask;
    rv32i_word address_b;
    rv32i_word wdata;
    logic      resp_b;
    rv32i_word rdata_b;
    logic      mem_read;
    logic      mem_write;
    rv32i_word mem_address;
    rv32i_word mem_wdata;
    logic [3:0] mem_wmask;
    logic      mem_resp;
    rv32i_word mem_rdata;
    modport slave (
        input  read_a, address_a, read_b, write, wmask, address_b, wdata, mem_resp, mem_rdata,
        output resp_a, rdata_a, resp_b, rdata_b, mem_read, mem_write, mem_address, mem_wdata, mem_wmask
    );
    modport master (
        output read_a, address_a, read_b, write, wmask, address_b, wdata, mem_resp, mem_rdata,
        input  resp_a, rdata_a, resp_b, rdata_b, mem_read, mem_write, mem_address, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter_arb_grant.sv
// mem_port_arbiter_arb_grant: picks which pending port to serve.
// ARB_ROUND_ROBIN_EN alternates on conflict; otherwise port B has fixed priority.
module mem_port_arbiter_arb_grant
    import mem_port_arbiter_pkg::*;
(
    input  logic      i_pend_a,
    input  logic      i_pend_b,
    input  arb_port_t i_last,
    output logic      o_valid,
    output arb_port_t o_grant
);
    assign o_valid = i_pend_a | i_pend_b;
`ifdef ARB_ROUND_ROBIN_EN
    always_comb o_grant = arb_port_t'((i_pend_a && i_pend_b) ? (i_last == ARB_A) : i_pend_b);
`else
    logic w_unused_last;
    assign w_unused_last = i_last;
    always_comb o_grant = arb_port_t'(i_pend_b);
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges instruction port A and data port B onto one memory port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate grants on conflict; the default build gives port B fixed priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;
    state_t     r_state;
    arb_port_t  r_port;
    logic       r_mem_read;
    logic       r_mem_write;
    logic       r_resp_a;
    logic       r_resp_b;
    rv32i_word  r_address;
    rv32i_word  r_wdata;
    logic [3:0] r_wmask;
    rv32i_word  r_rdata_a;
    rv32i_word  r_rdata_b;
    logic       w_valid;
    arb_port_t  w_grant;
    arb_port_t  w_last;

    mem_port_arbiter_arb_grant u_grant (
        .i_pend_a (bus.read_a),
        .i_pend_b (bus.read_b | bus.write),
        .i_last   (w_last),
        .o_valid  (w_valid),
        .o_grant  (w_grant)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_port_t r_last;
    always_ff @(posedge clk) begin
        if (reset)
            r_last <= ARB_A;
        else if (r_state == IDLE && w_valid)
            r_last <= w_grant;
    end
    assign w_last = r_last;
`else
    assign w_last = ARB_A;
`endif

    // Memory strobes are registered and only come from latched request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_port      <= ARB_A;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_resp_a    <= 1'b0;
            r_resp_b    <= 1'b0;
            r_address   <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state <= SERVE;
                        r_port  <= w_grant;
                        if (w_grant == ARB_B) begin
                            r_address   <= bus.address_b;
                            r_wdata     <= bus.wdata;
                            r_wmask     <= bus.wmask;
                            r_mem_write <= bus.write;
                            r_mem_read  <= ~bus.write;
                        end else begin
                            r_address   <= bus.address_a;
                            r_wdata     <= '0;
                            r_wmask     <= '0;
                            r_mem_write <= 1'b0;
                            r_mem_read  <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (bus.mem_resp) begin
                        r_state     <= RESP;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_resp_a    <= (r_port == ARB_A);
                        r_resp_b    <= (r_port == ARB_B);
                        if (r_mem_read && r_port == ARB_A)
                            r_rdata_a <= bus.mem_rdata;
                        if (r_mem_read && r_port == ARB_B)
                            r_rdata_b <= bus.mem_rdata;
                    end
                end
                RESP: begin
                    r_state  <= IDLE;
                    r_resp_a <= 1'b0;
                    r_resp_b <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_address;
    assign bus.mem_wdata   = r_wdata;
    assign bus.mem_wmask   = r_wmask;
    assign bus.resp_a      = r_resp_a;
    assign bus.resp_b      = r_resp_b;
    assign bus.rdata_a     = r_rdata_a;
    assign bus.rdata_b     = r_rdata_b;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a transaction-level arbiter model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    int mem_wait = 0;
    int cnt = 0;
    logic auto_resp = 1'b0;
    logic man_resp = 1'b0;
    assign bus.mem_resp = auto_resp | man_resp;

    arb_port_t m_last = ARB_A;
    rv32i_word m_rdata_a = '0;
    rv32i_word m_rdata_b = '0;
    arb_port_t got_q[$];
    arb_port_t exp_order[4];

    function automatic rv32i_word mem_val(input rv32i_word a);
        return a ^ 32'hDEADBE8F;
    endfunction

    // Memory model: answers mem_wait cycles after a strobe appears, garbage on rdata otherwise.
    always @(negedge clk) begin
        if (bus.mem_read || bus.mem_write) begin
            if (cnt == mem_wait) begin
                auto_resp     <= 1'b1;
                bus.mem_rdata <= mem_val(bus.mem_address);
                cnt           <= 0;
            end else begin
                auto_resp     <= 1'b0;
                bus.mem_rdata <= $urandom;
                cnt           <= cnt + 1;
            end
        end else begin
            auto_resp     <= 1'b0;
            bus.mem_rdata <= $urandom;
            cnt           <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic ra, input logic rdb, input logic wr, input rv32i_word aa,
                          input rv32i_word ab, input rv32i_word wd, input logic [3:0] wm, input int k);
        arb_port_t g;
        logic ew;
        logic er;
        rv32i_word ea;
        logic [3:0] em;
        g = (rdb || wr) ? ARB_B : ARB_A;
`ifdef ARB_ROUND_ROBIN_EN
        if (ra && (rdb || wr) && m_last == ARB_B)
            g = ARB_A;
`endif
        ew = (g == ARB_B) && wr;
        er = !ew;
        ea = (g == ARB_B) ? ab : aa;
        em = (g == ARB_B) ? wm : 4'b0000;
        mem_wait = k;
        bus.read_a = ra;
        bus.read_b = rdb;
        bus.write = wr;
        bus.address_a = aa;
        bus.address_b = ab;
        bus.wdata = wd;
        bus.wmask = wm;
        @(negedge clk);
        bus.address_a = $urandom;
        bus.address_b = $urandom;
        bus.wdata = $urandom;
        bus.wmask = 4'($urandom);
        for (int i = 0; i <= k; i++) begin
            chk("serve_mem_read", bus.mem_read, er);
            chk("serve_mem_write", bus.mem_write, ew);
            chk("serve_mem_address", bus.mem_address, ea);
            chk("serve_mem_wmask", bus.mem_wmask, em);
            if (ew)
                chk("serve_mem_wdata", bus.mem_wdata, wd);
            chk("serve_resp_a", bus.resp_a, 1'b0);
            chk("serve_resp_b", bus.resp_b, 1'b0);
            @(negedge clk);
        end
        if (er && g == ARB_A)
            m_rdata_a = mem_val(ea);
        if (er && g == ARB_B)
            m_rdata_b = mem_val(ea);
        chk("resp_a", bus.resp_a, g == ARB_A);
        chk("resp_b", bus.resp_b, g == ARB_B);
        chk("resp_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("resp_rdata_a", bus.rdata_a, m_rdata_a);
        chk("resp_rdata_b", bus.rdata_b, m_rdata_b);
        got_q.push_back(bus.resp_b ? ARB_B : ARB_A);
        man_resp = 1'($urandom);
        bus.read_a = 1'b0;
        bus.read_b = 1'b0;
        bus.write = 1'b0;
        @(negedge clk);
        man_resp = 1'b0;
        chk("idle_resp", {bus.resp_a, bus.resp_b}, 2'b00);
        chk("idle_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("idle_rdata_a", bus.rdata_a, m_rdata_a);
        chk("idle_rdata_b", bus.rdata_b, m_rdata_b);
        m_last = g;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ra;
        logic rdb;
        logic wr;
        bus.read_a = 1'b0;
        bus.read_b = 1'b0;
        bus.write = 1'b0;
        bus.address_a = '0;
        bus.address_b = '0;
        bus.wdata = '0;
        bus.wmask = '0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {bus.mem_read, bus.mem_write, bus.resp_a, bus.resp_b}, 4'b0000);
        chk("rst_mem_address", bus.mem_address, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_wmask", bus.mem_wmask, 4'h0);
        chk("rst_rdata_a", bus.rdata_a, 32'h0);
        chk("rst_rdata_b", bus.rdata_b, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a stalled write on B, then a stray late mem_resp.
        mem_wait = 1000;
        bus.write = 1'b1;
        bus.address_b = 32'h200;
        bus.wdata = 32'hCAFEF00D;
        bus.wmask = 4'hF;
        @(negedge clk);
        chk("mid_mem_write", bus.mem_write, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("mid_resp_b", bus.resp_b, 1'b0);
        man_resp = 1'b1;
        @(negedge clk);
        man_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_resp", {bus.resp_a, bus.resp_b}, 2'b00);
            chk("late_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
            @(negedge clk);
        end
        m_last = ARB_A;
        m_rdata_a = '0;
        m_rdata_b = '0;

        // Both ports requesting on every grant opportunity.
        got_q.delete();
        for (int i = 0; i < 4; i++)
            do_txn(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4), 32'h0, 4'hF, i % 2);
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{ARB_B, ARB_A, ARB_B, ARB_A};
`else
        exp_order = '{ARB_B, ARB_B, ARB_B, ARB_B};
`endif
        for (int i = 0; i < 4; i++)
            chk("conflict_order", got_q[i], exp_order[i]);
        do_txn(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 32'h0, 4'h0, 0);
        chk("a_after_b_drops", got_q[4], ARB_A);

        do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0060, $urandom, $urandom, 4'($urandom), 0);
        chk("single_read_a", bus.rdata_a, 32'hDEADBEEF);
        do_txn(1'b0, 1'b0, 1'b1, $urandom, 32'h100, 32'h12345678, 4'b0011, 3);
        do_txn(1'b0, 1'b1, 1'b1, $urandom, 32'h104, 32'h0BADF00D, 4'hF, 1);
        chk("rw_last_grant", got_q[got_q.size() - 1], ARB_B);

        for (int n = 0; n < 40; n++) begin
            ra = 1'($urandom);
            rdb = 1'($urandom);
            wr = 1'($urandom);
            if (!ra && !rdb && !wr)
                rdb = 1'b1;
            do_txn(ra, rdb, wr, $urandom, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
